mult_pipe_2sc_hs: RTL and testbench

- Parametrised successor to the fixed 8x8 two's-complement pipelined multiplier.
- Operand width and pipeline depth are configurable. Signed or unsigned mode is selected per transaction.
- Adds valid/ready handshaking with per-stage bubble collapsing, plus a sideband tag carried alongside each product.
- Sits between datapath producers and consumers that may apply backpressure (filters, MAC front-ends).

---
 rtl/mult_pipe_2sc_hs_if.sv | 29 ++
 rtl/mult_pipe_2sc_hs.sv | 92 +++++++++
 tb/tb_mult_pipe_2sc_hs.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_pipe_2sc_hs_if.sv
// Handshake bundle for the pipelined multiplier: producer side (operands,
// mode, tag) and consumer side (product, tag), each with valid/ready.
interface mult_pipe_2sc_hs_if #(
  parameter int W     = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sgn;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   y;
  logic [TAG_W-1:0] out_tag;

  // Driver of transactions and sink of results
  modport master (
    output in_valid, a, b, sgn, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag
  );

  // The multiplier itself
  modport slave (
    input  in_valid, a, b, sgn, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag
  );
endinterface

// File: rtl/mult_pipe_2sc_hs.sv
// Parametrised W x W multiplier, signed/unsigned per transaction, STAGES
// register stages with valid/ready flow control and bubble collapsing.
// The product is formed combinationally ahead of stage 0; later stages only
// carry {product, tag} so synthesis is free to retime the multiplier.

// One pipeline stage: loads when allowed to advance, otherwise holds.
// Data only moves with a valid token so idle inputs never disturb it.
module mult_pipe_2sc_hs_stage #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          vld_in,
  input  logic [DW-1:0] d_in,
  output logic          vld_out,
  output logic [DW-1:0] d_out
);
  // Stage register: reset clears everything, adv loads the upstream slot
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_out <= 1'b0;
      d_out   <= '0;
    end else if (adv) begin
      vld_out <= vld_in;
      if (vld_in) d_out <= d_in;
    end
  end
endmodule

module mult_pipe_2sc_hs #(
  parameter int W      = 8,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mult_pipe_2sc_hs_if.slave   bus
);
  localparam int PW = 2 * W;
  localparam int DW = PW + TAG_W;

  typedef struct packed {
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Index 0 is the input side; index i+1 is the output of stage i
  logic   [STAGES:0]   vld_pipe;
  stage_t [STAGES:0]   dat_pipe;
  logic   [STAGES-1:0] adv;
  logic   [PW-1:0]     a_ext;
  logic   [PW-1:0]     b_ext;

  // Extend both operands to 2W per the mode bit; the low 2W bits of the
  // 2W x 2W product are then exact for both signed and unsigned operands
  always_comb begin
    a_ext = {{W{bus.sgn & bus.a[W-1]}}, bus.a};
    b_ext = {{W{bus.sgn & bus.b[W-1]}}, bus.b};
  end

  assign vld_pipe[0]      = bus.in_valid;
  assign dat_pipe[0].prod = a_ext * b_ext;
  assign dat_pipe[0].tag  = bus.in_tag;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      // A stage may advance if it is empty or the stage ahead can advance
      if (g == STAGES - 1) begin : g_last
        assign adv[g] = !vld_pipe[g+1] || bus.out_ready;
      end else begin : g_mid
        assign adv[g] = !vld_pipe[g+1] || adv[g+1];
      end

      mult_pipe_2sc_hs_stage #(.DW(DW)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .adv     (adv[g]),
        .vld_in  (vld_pipe[g]),
        .d_in    (dat_pipe[g]),
        .vld_out (vld_pipe[g+1]),
        .d_out   (dat_pipe[g+1])
      );
    end
  endgenerate

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.y         = dat_pipe[STAGES].prod;
  assign bus.out_tag   = dat_pipe[STAGES].tag;
endmodule

// File: tb/tb_mult_pipe_2sc_hs.sv
// Directed bench for mult_pipe_2sc_hs at W=8, STAGES=8, TAG_W=4.
module tb_mult_pipe_2sc_hs;
  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mult_pipe_2sc_hs_if #(.W(8), .TAG_W(4)) bus ();

  mult_pipe_2sc_hs #(.W(8), .STAGES(8), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.sgn      = 1'($urandom);
    bus.in_tag   = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.out_ready = 1'b1; idle_inputs();
    tick(); tick();
    reset = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.y !== 16'h0) begin tests_failed++; $display("FAIL reset_y: got %h want 0000", bus.y); end
    tests_run++; if (bus.out_tag !== 4'h0) begin tests_failed++; $display("FAIL reset_tag: got %h want 0", bus.out_tag); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  // Signed, unsigned and mixed-mode vectors back to back; latency check
  task automatic test_arith();
    logic [7:0]  va [9] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  vb [9] = '{8'h80, 8'h01, 8'h80, 8'h80, 8'hFF, 8'h80, 8'hFF, 8'h02, 8'h02};
    logic        vs [9] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [15:0] vy [9] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0000, 16'hFE01,
                            16'h4000, 16'h0001, 16'h01FE, 16'hFFFE};
    bus.out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 9) begin
        bus.in_valid = 1'b1; bus.a = va[c]; bus.b = vb[c]; bus.sgn = vs[c]; bus.in_tag = 4'(c + 1);
      end else idle_inputs();
      tick();
      if (c == 6 || c == 16) begin
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL arith_idle[%0d]: got valid %b want 0", c, bus.out_valid); end
      end else if (c >= 7) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.y !== vy[c-7] || bus.out_tag !== 4'(c - 6)) begin
          tests_failed++;
          $display("FAIL arith[%0d]: got v=%b y=%h tag=%h want v=1 y=%h tag=%h",
                   c - 7, bus.out_valid, bus.y, bus.out_tag, vy[c-7], 4'(c - 6));
        end
      end
    end
  endtask

  // 20 consecutive accepts yield 20 consecutive results, in order
  task automatic test_back_to_back();
    int got = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c <= 27; c++) begin
      if (c < 20) begin
        bus.in_valid = 1'b1; bus.a = 8'(c); bus.b = 8'd3; bus.sgn = 1'b0; bus.in_tag = 4'(c);
      end else idle_inputs();
      tick();
      if (c >= 7 && c <= 26) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.y !== 16'(3 * (c - 7)) || bus.out_tag !== 4'(c - 7)) begin
          tests_failed++;
          $display("FAIL b2b[%0d]: got v=%b y=%h tag=%h want v=1 y=%h tag=%h",
                   c - 7, bus.out_valid, bus.y, bus.out_tag, 16'(3 * (c - 7)), 4'(c - 7));
        end
      end
      if (bus.out_valid === 1'b1) got++;
    end
    tests_run++; if (got != 20) begin tests_failed++; $display("FAIL b2b_count: got %0d want 20", got); end
  endtask

  // Stall the output: exactly 8 accepts, stable output, ordered drain
  task automatic test_backpressure();
    int   n = 0;
    logic ir;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1'b1; bus.a = 8'(n + 1); bus.b = 8'd5; bus.sgn = 1'b0; bus.in_tag = 4'(n);
      #1 ir = bus.in_ready;
      tick();
      if (ir) n++;
    end
    tests_run++; if (n != 8) begin tests_failed++; $display("FAIL bp_accepts: got %0d want 8", n); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.y !== 16'd5 || bus.out_tag !== 4'd0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b y=%h tag=%h want v=1 y=0005 tag=0", k, bus.out_valid, bus.y, bus.out_tag);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd5; bus.sgn = 1'b0; bus.in_tag = 4'd8;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.y !== 16'(5 * (k + 1)) || bus.out_tag !== 4'(k)) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: got v=%b y=%h tag=%h want v=1 y=%h tag=%h",
                 k, bus.out_valid, bus.y, bus.out_tag, 16'(5 * (k + 1)), 4'(k));
      end
      tick();
    end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
  endtask

  // Every-third-cycle input under stall: bubbles collapse, ready holds
  // until all eight stages are occupied
  task automatic test_sparse();
    int n = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c % 3 == 0 && n < 8) begin
        bus.in_valid = 1'b1; bus.a = 8'(n + 2); bus.b = 8'h10; bus.sgn = 1'b0; bus.in_tag = 4'(n);
      end else idle_inputs();
      #1;
      tests_run++;
      if (bus.in_ready !== (n < 8)) begin
        tests_failed++;
        $display("FAIL sparse_ready[%0d]: got %b want %b", c, bus.in_ready, (n < 8));
      end
      if (bus.in_valid && bus.in_ready) n++;
      tick();
    end
    tests_run++; if (n != 8) begin tests_failed++; $display("FAIL sparse_accepts: got %0d want 8", n); end
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.y !== 16'((k + 2) * 16) || bus.out_tag !== 4'(k)) begin
        tests_failed++;
        $display("FAIL sparse_drain[%0d]: got v=%b y=%h tag=%h want v=1 y=%h tag=%h",
                 k, bus.out_valid, bus.y, bus.out_tag, 16'((k + 2) * 16), 4'(k));
      end
      tick();
    end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL sparse_empty: got %b want 0", bus.out_valid); end
  endtask

  // Reset with 5 in flight: all discarded, next transaction full latency
  task automatic test_reset_midflight();
    int stale = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.a = 8'(c + 1); bus.b = 8'd2; bus.sgn = 1'b0; bus.in_tag = 4'(c + 10);
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.y !== 16'h0 || bus.out_tag !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_flush: got v=%b y=%h tag=%h want v=0 y=0000 tag=0", bus.out_valid, bus.y, bus.out_tag);
    end
    bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.sgn = 1'b0; bus.in_tag = 4'd5;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    tick();
    idle_inputs();
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) begin
        if (bus.out_valid !== 1'b0) stale++;
      end else begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.y !== 16'd12 || bus.out_tag !== 4'd5) begin
          tests_failed++;
          $display("FAIL rst_first: got v=%b y=%h tag=%h want v=1 y=000c tag=5", bus.out_valid, bus.y, bus.out_tag);
        end
      end
    end
    tests_run++; if (stale != 0) begin tests_failed++; $display("FAIL rst_stale: got %0d early results want 0", stale); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_empty: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_sparse();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
